// File: rtl/gru_seq_loader.sv
// Sequence loader for a GRU cell: assembles x_t from an element stream,
// fires the cell once per timestep and returns the final hidden state.
module gru_seq_loader #(
  parameter int D          = 64,
  parameter int H          = 16,
  parameter int DATA_WIDTH = 26,
  parameter int SEQ_W      = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                seq_start,
  input  logic [SEQ_W-1:0]                    seq_len,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [DATA_WIDTH-1:0]        in_data,
  output logic signed [D-1:0][DATA_WIDTH-1:0] x_t,
  output logic signed [H-1:0][DATA_WIDTH-1:0] h_t_prev,
  output logic                                gru_start,
  input  logic                                gru_done,
  input  logic signed [H-1:0][DATA_WIDTH-1:0] gru_h_t,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [H-1:0][DATA_WIDTH-1:0] out_h,
  output logic                                busy
);

  localparam int IW = (D > 1) ? $clog2(D) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_FIRE = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic [2:0]                         state_q, state_d;
  logic [IW-1:0]                      idx_q, idx_d;
  logic [SEQ_W-1:0]                   step_q, step_d;
  logic [SEQ_W-1:0]                   len_q, len_d;
  logic [D-1:0][DATA_WIDTH-1:0]       x_q, x_d;
  logic [H-1:0][DATA_WIDTH-1:0]       h_q, h_d;
  logic                               xfer;

  assign in_ready  = (state_q == S_LOAD);
  assign gru_start = (state_q == S_FIRE);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign xfer      = in_ready & in_valid;
  assign x_t       = x_q;
  assign h_t_prev  = h_q;
  assign out_h     = h_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    step_d  = step_q;
    len_d   = len_q;
    x_d     = x_q;
    h_d     = h_q;
    unique case (state_q)
      S_IDLE: begin
        if (seq_start) begin
          h_d     = '0;
          idx_d   = '0;
          step_d  = '0;
          len_d   = seq_len;
          state_d = (seq_len == '0) ? S_OUT : S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          x_d[idx_q] = in_data;
          if (idx_q == IW'(D - 1)) begin
            idx_d   = '0;
            state_d = S_FIRE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_FIRE: state_d = S_WAIT;
      S_WAIT: begin
        // x_t/h_t_prev stay frozen until the cell answers
        if (gru_done) begin
          h_d     = gru_h_t;
          step_d  = step_q + SEQ_W'(1);
          state_d = (step_d == len_q) ? S_OUT : S_LOAD;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      step_q  <= '0;
      len_q   <= '0;
      x_q     <= '0;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      len_q   <= len_d;
      x_q     <= x_d;
      h_q     <= h_d;
    end
  end

endmodule

// File: tb/tb_gru_seq_loader.sv
// Randomized scoreboard bench for gru_seq_loader with a stub GRU cell
// and a sequence-level reference model.
module tb_gru_seq_loader;

  localparam int D  = 64;
  localparam int H  = 16;
  localparam int DW = 26;
  localparam int SW = 8;

  typedef logic [D-1:0][DW-1:0] xv_t;
  typedef logic [H-1:0][DW-1:0] hv_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          seq_start;
  logic [SW-1:0] seq_len;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  xv_t           x_t;
  hv_t           h_t_prev;
  logic          gru_start;
  logic          gru_done;
  hv_t           gru_h_t;
  logic          out_valid;
  logic          out_ready;
  hv_t           out_h;
  logic          busy;

  logic          drv_start, poke_start;
  logic [SW-1:0] drv_len;
  logic          stub_done, spur_done, poke_en;
  hv_t           stub_h, hs;
  xv_t           xs;
  int            gru_lat, gru_mode;

  int checks = 0;
  int passes = 0;
  int start_cnt = 0;
  int out_cnt = 0;

  xv_t exp_x[$];
  hv_t exp_h[$];
  hv_t exp_out[$];

  assign seq_start = drv_start | poke_start;
  assign seq_len   = poke_start ? SW'(7) : drv_len;
  assign gru_done  = stub_done | spur_done;
  assign gru_h_t   = spur_done ? {H{DW'(26'h2AAAAAA)}} : stub_h;

  always #5 clk = ~clk;

  gru_seq_loader #(.D(D), .H(H), .DATA_WIDTH(DW), .SEQ_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .seq_start(seq_start), .seq_len(seq_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .x_t(x_t), .h_t_prev(h_t_prev),
    .gru_start(gru_start), .gru_done(gru_done), .gru_h_t(gru_h_t),
    .out_valid(out_valid), .out_ready(out_ready), .out_h(out_h),
    .busy(busy)
  );

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_x(string name, xv_t a, xv_t e);
    int k = -1;
    for (int i = 0; i < D; i++) if (a[i] !== e[i] && k < 0) k = i;
    if (k < 0) chk(name, 64'(a[0]), 64'(e[0]));
    else chk($sformatf("%s[%0d]", name, k), 64'(a[k]), 64'(e[k]));
  endtask

  task automatic chk_h(string name, hv_t a, hv_t e);
    int k = -1;
    for (int i = 0; i < H; i++) if (a[i] !== e[i] && k < 0) k = i;
    if (k < 0) chk(name, 64'(a[0]), 64'(e[0]));
    else chk($sformatf("%s[%0d]", name, k), 64'(a[k]), 64'(e[k]));
  endtask

  // Cell behaviour used by both the stub and the reference model
  function automatic hv_t gru_ref(int mode, hv_t h, xv_t x);
    hv_t r;
    for (int j = 0; j < H; j++) begin
      case (mode)
        0:       r[j] = DW'(32'h10000);
        1:       r[j] = h[j] + DW'(32'h10000);
        default: r[j] = h[j] + x[j] + DW'(j);
      endcase
    end
    return r;
  endfunction

  // Monitor: pops expectations whenever the DUT presents something
  always @(negedge clk) begin
    if (rst_n) begin
      if (gru_start) begin
        start_cnt++;
        if (exp_x.size() == 0) begin
          chk("start_unexpected", 64'(start_cnt), 64'(0));
        end else begin
          chk_x("x_at_start", x_t, exp_x.pop_front());
          chk_h("h_at_start", h_t_prev, exp_h.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_out.size() == 0) chk("out_unexpected", 64'(out_cnt), 64'(0));
        else chk_h("out_h", out_h, exp_out.pop_front());
      end
    end
  end

  // Stub GRU cell with configurable latency
  initial begin
    stub_done  = 1'b0;
    stub_h     = '0;
    poke_start = 1'b0;
    forever begin
      @(negedge clk);
      if (gru_start) begin
        hs = h_t_prev;
        xs = x_t;
        for (int c = 0; c < gru_lat; c++) begin
          @(negedge clk);
          poke_start = poke_en && (c == 0);
        end
        poke_start = 1'b0;
        stub_h     = gru_ref(gru_mode, hs, xs);
        stub_done  = 1'b1;
        @(negedge clk);
        stub_done  = 1'b0;
      end
    end
  end

  task automatic issue_start(int len);
    @(posedge clk); #1;
    drv_start = 1'b1;
    drv_len   = SW'(len);
    @(posedge clk); #1;
    drv_start = 1'b0;
  endtask

  task automatic feed(logic [DW-1:0] el[$], int n, int pv, bit inject);
    int  idx = 0;
    int  cyc = 0;
    bit  v;
    bit  spurred = 0;
    while (idx < n) begin
      @(posedge clk); #1;
      spur_done = 1'b0;
      if (inject && idx == 10 && !spurred) begin
        spur_done = 1'b1;
        spurred   = 1;
      end
      v        = ($urandom_range(99) < pv);
      in_valid = v;
      in_data  = el[idx];
      if (v && in_ready) idx++;
      cyc++;
      if (cyc > 50 * n + 1000) begin
        chk("feed_timeout", 64'(idx), 64'(n));
        break;
      end
    end
  endtask

  task automatic run_seq(int len, int mode, int lat, int pv, bit ramp, bit inject);
    hv_t           h;
    xv_t           x;
    logic [DW-1:0] el[$];
    logic [DW-1:0] v;
    int            sc0 = start_cnt;
    int            oc0 = out_cnt;
    int            cyc = 0;
    gru_lat  = lat;
    gru_mode = mode;
    poke_en  = inject;
    h = '0;
    for (int k = 0; k < len; k++) begin
      for (int i = 0; i < D; i++) begin
        v = ramp ? DW'(i + 1) : DW'($urandom);
        el.push_back(v);
        x[i] = v;
      end
      exp_x.push_back(x);
      exp_h.push_back(h);
      h = gru_ref(mode, h, x);
    end
    exp_out.push_back(h);
    issue_start(len);
    if (len == 0) chk("len0_out_valid", 64'(out_valid), 64'(1));
    if (len > 0) feed(el, len * D, pv, inject);
    while (out_cnt == oc0 && cyc < 2000) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      spur_done = 1'b0;
      out_ready = $urandom_range(1);
      cyc++;
    end
    if (cyc >= 2000) chk("out_timeout", 64'(out_cnt - oc0), 64'(1));
    out_ready = 1'b0;
    poke_en   = 1'b0;
    chk("out_valid_drop", 64'(out_valid), 64'(0));
    chk("busy_idle", 64'(busy), 64'(0));
    chk("start_count", 64'(start_cnt - sc0), 64'(len));
  endtask

  task automatic chk_zero_idle(string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    chk({tag, "_gru_start"}, 64'(gru_start), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk_x({tag, "_x_t"}, x_t, '0);
    chk_h({tag, "_h_t_prev"}, h_t_prev, '0);
    chk_h({tag, "_out_h"}, out_h, '0);
  endtask

  task automatic reset_mid_wait();
    logic [DW-1:0] el[$];
    xv_t           x;
    int            sc0 = start_cnt;
    int            cyc = 0;
    gru_lat  = 25;
    gru_mode = 1;
    for (int i = 0; i < D; i++) begin
      x[i] = DW'($urandom);
      el.push_back(x[i]);
    end
    exp_x.push_back(x);
    exp_h.push_back('0);
    issue_start(2);
    feed(el, D, 80, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (start_cnt == sc0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("wait_busy", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_zero_idle("rst_wait");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk_zero_idle("post_done");
    chk("abort_starts", 64'(start_cnt - sc0), 64'(1));
  endtask

  initial begin
    rst_n     = 1'b1;
    drv_start = 1'b0;
    drv_len   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    spur_done = 1'b0;
    poke_en   = 1'b0;
    gru_lat   = 1;
    gru_mode  = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_idle("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_seq(1, 0, 10, 100, 1, 0);
    run_seq(3, 1, 4, 100, 0, 0);
    run_seq(2, 2, 3, 50, 0, 0);
    run_seq(0, 1, 1, 100, 0, 0);
    run_seq(2, 1, 6, 70, 0, 1);
    reset_mid_wait();
    for (int r = 0; r < 3; r++)
      run_seq($urandom_range(1, 3), $urandom_range(0, 2),
              $urandom_range(1, 8), $urandom_range(30, 100), 0, 0);
    run_seq(255, 1, 1, 100, 0, 0);

    chk("queues_drained", 64'(exp_x.size() + exp_out.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gru_seq_loader.md
GRU_SEQ_LOADER -- requirements
Module: gru_seq_loader

Interface
REQ-001 Parameter D, default 64, input vector length (elements of x_t).
REQ-002 Parameter H, default 16, hidden state length.
REQ-003 Parameter DATA_WIDTH, default 26, signed Q10.16 element width.
REQ-004 Parameter SEQ_W, default 8, width of sequence-length field.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 seq_start  input  1  one-cycle request to begin a sequence; honoured only in IDLE.
REQ-008 seq_len  input  SEQ_W  number of timesteps; sampled when seq_start is honoured.
REQ-009 in_valid / in_ready  input / output  1 / 1  element stream handshake; transfer when both high.
REQ-010 in_data  input  DATA_WIDTH signed  one x_t element, index order 0..D-1.
REQ-011 x_t  output  D x DATA_WIDTH signed  assembled input vector to the GRU cell.
REQ-012 h_t_prev  output  H x DATA_WIDTH signed  recurrent state to the GRU cell.
REQ-013 gru_start  output  1  one-cycle start pulse to the GRU cell.
REQ-014 gru_done / gru_h_t  input  1 / H x DATA_WIDTH  GRU completion pulse and result.
REQ-015 out_valid / out_ready  output / input  1 / 1  final hidden-state handshake.
REQ-016 out_h  output  H x DATA_WIDTH signed  final hidden state, valid when out_valid high.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states IDLE, LOAD, FIRE, WAIT, OUT; exactly one active.
REQ-019 IDLE: seq_start=1 and seq_len>0 -> latch seq_len, clear h_t_prev to 0, clear elem_idx and step counters, go LOAD.
REQ-020 IDLE: seq_start=1 and seq_len=0 -> clear h_t_prev to 0, go OUT directly (out_h all zero).
REQ-021 seq_start outside IDLE SHALL be ignored with no state change.
REQ-022 in_ready SHALL be 1 only in LOAD (combinational from state, not from in_valid).
REQ-023 LOAD: each transfer writes in_data to x_t[elem_idx], elem_idx+1; no transfer -> hold.
REQ-024 Transfer with elem_idx=D-1 -> elem_idx wraps to 0, go FIRE next cycle.
REQ-025 FIRE: gru_start=1 for exactly one cycle, go WAIT; x_t and h_t_prev stable from FIRE until gru_done.
REQ-026 WAIT: on gru_done=1 capture gru_h_t into h_t_prev same edge; step+1; if new step equals latched seq_len go OUT else go LOAD.
REQ-027 gru_done outside WAIT SHALL be ignored; gru_h_t sampled only on gru_done in WAIT.
REQ-028 No timeout in WAIT; state held indefinitely until gru_done.
REQ-029 OUT: out_valid=1, out_h = h_t_prev, held stable until out_ready=1; on out_ready go IDLE next cycle.
REQ-030 out_valid and out_ready high same cycle completes; out_valid low the following cycle.
REQ-031 Data passed through unmodified; no arithmetic, saturation or rounding on elements.
REQ-032 Minimum per-timestep overhead: D load cycles + 1 FIRE + GRU latency + 1 capture cycle.
REQ-033 step counter SEQ_W bits; seq_len=2^SEQ_W-1 SHALL complete without overflow.

Reset
REQ-034 rst_n low asynchronously forces IDLE; in_ready, gru_start, out_valid, busy = 0.
REQ-035 Reset clears x_t, h_t_prev, out_h, elem_idx, step and latched seq_len to 0.
REQ-036 Reset asserted mid-LOAD or mid-WAIT abandons the sequence; later gru_done ignored until next WAIT.

Verification
REQ-037 seq_len=1, stream elements 1..64, gru_done after 10 cycles with gru_h_t all 0x0010000 -> single gru_start, x_t[i]=i+1, out_valid with out_h all 0x0010000.
REQ-038 seq_len=3, stub GRU returns h_prev+1.0 -> three gru_start pulses, h_t_prev seen at each start 0,1.0,2.0, final out_h all 3.0.
REQ-039 in_valid toggling randomly 50% in LOAD -> x_t still holds elements in order; gru_start only after 64th transfer.
REQ-040 seq_len=0 -> out_valid within 1 cycle, out_h all zero, no gru_start.
REQ-041 seq_start during WAIT and spurious gru_done during LOAD -> no state change, no capture.
REQ-042 rst_n low mid-WAIT, then gru_done arrives -> block in IDLE, outputs zero, busy=0, no capture.
